// File: rtl/mppt_po_seq.sv
// mppt_po_seq: perturb-and-observe MPPT iteration sequencer.
// Settles, triggers the ADC, strobes the power datapath and steps the duty.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   run               tracking enable (level)
//   adc_valid         ADC conversion done pulse
//   pot_act, pot_ant  current / previous power (12-bit unsigned)
//   adc_start         ADC trigger pulse
//   en[3:0]           one-hot datapath strobes (mult, latch, compare, update)
//   duty              PWM duty command
//   busy              high whenever not idle
//   fault             sticky ADC timeout flag
//
// Optional: define MPPT_SEQ_TIMEOUT_EN to add the ADC watchdog and ERROR state.
module mppt_po_seq #(
   parameter int DUTY_W     = 8,
   parameter int DUTY_INIT  = 128,
   parameter int DUTY_MIN   = 16,
   parameter int DUTY_MAX   = 240,
   parameter int STEP       = 4,
   parameter int SETTLE_CYC = 1000,
   parameter int TIMEOUT    = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              adc_valid,
   input  logic [11:0]       pot_act,
   input  logic [11:0]       pot_ant,
   output logic              adc_start,
   output logic [3:0]        en,
   output logic [DUTY_W-1:0] duty,
   output logic              busy,
   output logic              fault
);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      MULT,
      LATCH,
      COMPARE,
      UPDATE
`ifdef MPPT_SEQ_TIMEOUT_EN
      , ERROR
`endif
   } state_t;

   localparam int WW    = DUTY_W + 1;
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [WW-1:0]     STEP_W   = WW'(STEP);
   localparam logic [WW-1:0]     MAX_W    = WW'(DUTY_MAX);
   localparam logic [WW-1:0]     LO_W     = WW'(DUTY_MIN + STEP);
   localparam logic [DUTY_W-1:0] D_MAX    = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0] D_MIN    = DUTY_W'(DUTY_MIN);
   localparam logic [DUTY_W-1:0] D_INIT   = DUTY_W'(DUTY_INIT);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DUTY_W-1:0]  duty_q, duty_d;
   logic               dir_q, dir_d;
   logic               first_q, first_d;
   logic               smp_q;
   logic [3:0]         en_c;
   logic               start_c;
   logic               accept;
   logic [WW-1:0]      up, dn;

`ifdef MPPT_SEQ_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   logic [TMO_W-1:0] tcnt_q, tcnt_d;
   logic             fault_q;
`endif

   // adc_start only on the first SAMPLE cycle; a valid in that cycle is
   // stale (belongs to no trigger of ours) and is ignored.
   assign start_c = (state_q == SAMPLE) && !smp_q;
   assign accept  = (state_q == SAMPLE) && adc_valid && !start_c;

   // One extra bit so +STEP / -STEP never wraps before clamping.
   assign up = {1'b0, duty_q} + STEP_W;
   assign dn = {1'b0, duty_q} - STEP_W;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      duty_d  = duty_q;
      dir_d   = dir_q;
      first_d = first_q;
      en_c    = 4'b0000;
`ifdef MPPT_SEQ_TIMEOUT_EN
      tcnt_d  = '0;
`endif
      case (state_q)
         IDLE: begin
            if (run) begin
               state_d = SETTLE;
               first_d = 1'b1;
               cnt_d   = '0;
            end
         end
         SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SAMPLE: begin
            if (accept) begin
               state_d = MULT;
            end
`ifdef MPPT_SEQ_TIMEOUT_EN
            else if (tcnt_q == TMO_LAST) begin
               state_d = ERROR;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
`endif
         end
         MULT: begin
            en_c    = 4'b0001;
            state_d = LATCH;
         end
         LATCH: begin
            en_c    = 4'b0010;
            state_d = COMPARE;
         end
         COMPARE: begin
            en_c    = 4'b0100;
            state_d = UPDATE;
            if (first_q) begin
               first_d = 1'b0;
            end else if (pot_act < pot_ant) begin
               dir_d = ~dir_q;
            end
         end
         UPDATE: begin
            en_c    = 4'b1000;
            state_d = run ? SETTLE : IDLE;
            // Hitting a clamp reverses direction so the next step backs off.
            if (dir_q) begin
               if (up >= MAX_W) begin
                  duty_d = D_MAX;
                  dir_d  = 1'b0;
               end else begin
                  duty_d = up[DUTY_W-1:0];
               end
            end else begin
               if ({1'b0, duty_q} <= LO_W) begin
                  duty_d = D_MIN;
                  dir_d  = 1'b1;
               end else begin
                  duty_d = dn[DUTY_W-1:0];
               end
            end
         end
`ifdef MPPT_SEQ_TIMEOUT_EN
         ERROR: begin
            state_d = ERROR;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         duty_q  <= D_INIT;
         dir_q   <= 1'b1;
         first_q <= 1'b1;
         smp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         duty_q  <= duty_d;
         dir_q   <= dir_d;
         first_q <= first_d;
         smp_q   <= (state_q == SAMPLE);
      end
   end

`ifdef MPPT_SEQ_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         tcnt_q  <= tcnt_d;
         fault_q <= fault_q | (state_d == ERROR);
      end
   end

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   assign adc_start = start_c;
   assign en        = en_c;
   assign duty      = duty_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: doc/mppt_po_seq.md
# mppt_po_seq

Perturb-and-observe sequencer for the open-loop MPPT datapath. It paces each tracking iteration: settle after a duty change, trigger the ADC, then walk the one-hot enable strobes `en[3:0]` that clock the power multiplier, the power register pair (current and previous power) and the comparison stage. It reads back the current and previous power (`pot_act`, `pot_ant`) and steps the converter duty cycle in the direction that increases power. It sits between the ADC interface and the PWM generator.

## Interface
Reset is synchronous, active-high (`rst`); single clock `clk`.

Parameters:
- `DUTY_W`, 8: duty-cycle width.
- `DUTY_INIT`, 128: duty value at reset.
- `DUTY_MIN`, 16: lower duty clamp.
- `DUTY_MAX`, 240: upper duty clamp.
- `STEP`, 4: perturbation step size.
- `SETTLE_CYC`, 1000: cycles waited after a duty change; must be ≥1.
- `TIMEOUT`, 4096: ADC watchdog limit; used only with the macro in Configuration.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `run`  in  1  tracking enable (level).
- `adc_valid`  in  1  ADC conversion done (1-cycle pulse).
- `pot_act`  in  12  current power from the power register.
- `pot_ant`  in  12  previous power from the power register.
- `adc_start`  out  1  ADC trigger (1-cycle pulse).
- `en`  out  4  datapath strobes, one-hot or zero.
- `duty`  out  DUTY_W  PWM duty command.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `fault`  out  1  sticky ADC timeout flag; always 0 without the macro.

## Operation
- States: IDLE, SETTLE, SAMPLE, MULT, LATCH, COMPARE, UPDATE (plus ERROR with the macro).
- IDLE:
  - `en=0`.
  - When `run=1`, go to SETTLE and set the `first` flag to 1.
- SETTLE: count `SETTLE_CYC` cycles, then go to SAMPLE.
- SAMPLE:
  - `adc_start=1` on the entry cycle only.
  - Wait for `adc_valid`; a pulse coinciding with the `adc_start` cycle is ignored.
  - On an accepted `adc_valid`, go to MULT.
- Strobe states, each lasting exactly 1 cycle:
  - MULT: `en=4'b0001`.
  - LATCH: `en=4'b0010`.
  - COMPARE: `en=4'b0100`.
  - UPDATE: `en=4'b1000`.
- COMPARE sets the direction register `dir` (1 = increase duty):
  - `first=1`: no compare; `dir` unchanged; clear `first`.
  - `pot_act < pot_ant`: `dir <= ~dir`.
  - `pot_act ≥ pot_ant`: `dir` unchanged.
  - Compare is unsigned 12-bit.
- UPDATE computes the new duty:
  - `dir=1`: `duty <= min(duty+STEP, DUTY_MAX)`.
  - `dir=0`: `duty <= max(duty-STEP, DUTY_MIN)`.
  - Arithmetic uses `DUTY_W+1` bits so it never wraps.
  - If the result equals the clamp it was heading into, also set `dir <= ~dir`.
- After UPDATE:
  - `run=1`: go to SETTLE.
  - `run=0`: go to IDLE; `duty` and `dir` are held, `first` will be set on the next start.
- Dropping `run` mid-iteration does not abort; the iteration completes through UPDATE.
- `rst` at any cycle overrides everything and returns all reset values on the next edge.

## Timing
- Reset values:
  - state IDLE, `en=0`, `adc_start=0`, `busy=0`, `fault=0`.
  - `duty=DUTY_INIT`, `dir=1`, `first=1`, settle counter 0.
- `busy` rises the cycle after `run` is sampled high in IDLE.
- Cycle sequence:
  - `adc_start` is high in cycle `SETTLE_CYC+1` after leaving IDLE.
  - `en[0]` is high 1 cycle after the accepted `adc_valid`.
  - `en[1]`, `en[2]` and `en[3]` follow on consecutive cycles.
- `pot_act`/`pot_ant` are sampled in the COMPARE cycle, one cycle after the `en[1]` edge.
- `duty` changes on the clock edge ending UPDATE.
- Iteration length: `SETTLE_CYC + 1 + ADC latency + 4` cycles.

## Configuration
- `MPPT_SEQ_TIMEOUT_EN` defined:
  - SAMPLE counts cycles; if `TIMEOUT` cycles pass without `adc_valid`, go to ERROR.
  - ERROR sets `fault=1`, drives `en=0` and holds `duty`.
  - ERROR leaves only on `rst`; `fault` is cleared only by `rst`.
- Undefined: no counter and no ERROR state; SAMPLE waits indefinitely; `fault` is tied to 0.

## Test plan
- Reset, `SETTLE_CYC=3`, `run=1`, ADC answers 2 cycles after `adc_start`:
  - `adc_start` in cycle 4; `en` = 1, 2, 4, 8 on cycles 7–10.
  - First iteration: `duty` 128→132.
- Power rising (`pot_act=900`, `pot_ant=800`):
  - Direction kept; `duty` 132→136.
- Power falling (`pot_act=700`, `pot_ant=800`):
  - Direction flips; `duty` 136→132.
- `duty=238`, `dir=1`:
  - `duty` becomes 240 (clamped), `dir` goes to 0.
  - Next iteration gives `duty=236`.
- `run` dropped during SETTLE:
  - Iteration completes through UPDATE, then IDLE with `busy=0` and `duty` held.
  - Raising `run` again skips the compare on the first iteration.
- With `MPPT_SEQ_TIMEOUT_EN`, `TIMEOUT=8`, no `adc_valid`:
  - `fault=1` after 8 SAMPLE cycles, `en` stays 0.
  - `rst` clears `fault` and restores `duty=128`.
